mem_arbiter: RTL

Shares one downstream cache master port (toward L2/memory) between `n` upstream cache master ports, e.g. L1I, L1D and a page-table walker. Upstream requests are granted one at a time in round-robin order and forwarded from a registered copy. Each response is routed back to the port that owns its ID, including deferred (miss) responses that arrive after the grant has been released. The block sits between the L1 caches' `m_*` interfaces and the next-level cache's `s_*` channel 0.

---
 rtl/mem_arbiter.sv | 179 +++++++++++++++++
 1 files changed

// File: rtl/mem_arbiter.sv
// Round-robin arbiter sharing one downstream cache port between n upstream ports.
// Define MEM_ARB_FIXED_PRIO_EN to replace round-robin with fixed priority (port 0 highest).
module mem_arbiter #(
    parameter int n    = 2,
    parameter int blk  = 64,
    parameter int pend = 4
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic [255:0]                 flush,
    input  logic [n-1:0][7:0]            u_rqst,
    input  logic [n-1:0][7:0]            u_trsc,
    input  logic [n-1:0][blk-1:0]        u_strb,
    input  logic [n-1:0][63:0]           u_addr,
    input  logic [n-1:0][blk-1:0][7:0]   u_wdat,
    output logic [n-1:0][7:0]            u_resp,
    output logic [n-1:0][7:0]            u_miss,
    output logic [n-1:0][63:0]           u_ofst,
    output logic [n-1:0][blk-1:0][7:0]   u_rdat,
    output logic [7:0]                   d_rqst,
    output logic [7:0]                   d_trsc,
    output logic [blk-1:0]               d_strb,
    output logic [63:0]                  d_addr,
    output logic [blk-1:0][7:0]          d_wdat,
    input  logic [7:0]                   d_resp,
    input  logic [7:0]                   d_miss,
    input  logic [63:0]                  d_ofst,
    input  logic [blk-1:0][7:0]          d_rdat
);

    localparam int PW = (n > 1) ? $clog2(n) : 1;
    localparam int SW = (pend > 1) ? $clog2(pend) : 1;

    localparam logic [0:0] IDLE = 1'b0;
    localparam logic [0:0] BUSY = 1'b1;

    logic [0:0]             state;
    logic [PW-1:0]          rr;
    logic [PW-1:0]          gnt;
    logic [PW-1:0]          win;
    logic                   found;
    logic [n-1:0]           cand;
    logic [n-1:0]           sel;

    logic [pend-1:0]           tv;
    logic [pend-1:0][7:0]      tid;
    logic [pend-1:0][PW-1:0]   tport;
    logic [pend-1:0]           t_hit;
    logic [SW-1:0]             slot;

    logic full;
    logic busy;
    logic abort;
    logic g_hit;
    logic alloc;

    assign full  = &tv;
    assign busy  = (state == BUSY);
    assign abort = busy && flush[d_rqst];
    assign g_hit = busy && !abort && (d_resp != 8'd0) && (d_resp == d_rqst);
    assign alloc = g_hit && (d_miss != 8'd0) && !flush[d_miss] && !full;

    always_comb begin
        cand = '0;
        for (int i = 0; i < n; i++)
            cand[i] = (u_rqst[i] != 8'd0) && !flush[u_rqst[i]] && !full;
    end

    always_comb begin
        found = 1'b0;
        win   = '0;
`ifdef MEM_ARB_FIXED_PRIO_EN
        for (int i = n - 1; i >= 0; i--) begin
            if (cand[i]) begin
                found = 1'b1;
                win   = PW'(i);
            end
        end
`else
        // Descending scan so the nearest port after rr wins.
        for (int k = n; k >= 1; k--) begin
            if (cand[(int'(rr) + k) % n]) begin
                found = 1'b1;
                win   = PW'((int'(rr) + k) % n);
            end
        end
`endif
    end

    always_comb begin
        t_hit = '0;
        slot  = '0;
        for (int k = 0; k < pend; k++)
            t_hit[k] = tv[k] && (d_resp != 8'd0) && (tid[k] == d_resp) && !flush[tid[k]];
        for (int k = pend - 1; k >= 0; k--)
            if (!tv[k]) slot = SW'(k);
    end

    always_comb begin
        sel    = '0;
        u_resp = '0;
        u_miss = '0;
        u_ofst = '0;
        u_rdat = '0;
        for (int i = 0; i < n; i++) begin
            if (g_hit && gnt == PW'(i)) sel[i] = 1'b1;
            for (int k = 0; k < pend; k++)
                if (t_hit[k] && tport[k] == PW'(i)) sel[i] = 1'b1;
            if (sel[i]) begin
                u_resp[i] = d_resp;
                u_miss[i] = d_miss;
                u_ofst[i] = d_ofst;
                u_rdat[i] = d_rdat;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state  <= IDLE;
            rr     <= PW'(n - 1);
            gnt    <= '0;
            d_rqst <= '0;
            d_trsc <= '0;
            d_strb <= '0;
            d_addr <= '0;
            d_wdat <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (found) begin
                        gnt    <= win;
                        d_rqst <= u_rqst[win];
                        d_trsc <= u_trsc[win];
                        d_strb <= u_strb[win];
                        d_addr <= u_addr[win];
                        d_wdat <= u_wdat[win];
                        state  <= BUSY;
                    end
                end
                default: begin
                    if (abort || g_hit) begin
                        d_rqst <= '0;
                        d_trsc <= '0;
                        d_strb <= '0;
                        d_addr <= '0;
                        d_wdat <= '0;
                        state  <= IDLE;
                    end
                    if (g_hit) rr <= gnt;
                end
            endcase
        end
    end

    // Flush of a tracked miss ID wins over any update of that entry.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            tv    <= '0;
            tid   <= '0;
            tport <= '0;
        end else begin
            for (int k = 0; k < pend; k++) begin
                if (tv[k] && flush[tid[k]]) begin
                    tv[k] <= 1'b0;
                end else if (t_hit[k]) begin
                    if (d_miss == 8'd0) tv[k] <= 1'b0;
                    else tid[k] <= d_miss;
                end
            end
            if (alloc) begin
                tv[slot]    <= 1'b1;
                tid[slot]   <= d_miss;
                tport[slot] <= gnt;
            end
        end
    end

endmodule
